// File: rtl/phv_fifo.sv
// PHV FIFO between the parser and the match-action stage: DEPTH entries, 1-cycle
// fall-through latency. Define PHV_FIFO_DROP_CNT_EN to add the phv_drop_cnt port.
module phv_fifo #(
    parameter int PKT_HDR_LEN = 1124,
    parameter int DEPTH       = 8,
    parameter int AFULL_TH    = 6
) (
    input  logic                     axis_clk,
    input  logic                     areset,
    input  logic [PKT_HDR_LEN-1:0]   phv_in,
    input  logic                     phv_valid_in,
    output logic [PKT_HDR_LEN-1:0]   phv_out,
    output logic                     phv_valid_out,
    input  logic                     phv_ready_in,
    output logic [$clog2(DEPTH):0]   phv_count,
    output logic                     phv_afull
`ifdef PHV_FIFO_DROP_CNT_EN
    ,
    output logic [31:0]              phv_drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PKT_HDR_LEN-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic                   armed;
    logic                   full;
    logic                   push;
    logic                   pop;

    assign full          = (phv_count == CW'(DEPTH));
    assign phv_valid_out = (phv_count != '0);
    assign phv_afull     = (phv_count >= CW'(AFULL_TH));
    assign pop           = phv_valid_out & phv_ready_in;
    // A full FIFO still takes the push when the head leaves on the same edge.
    assign push          = phv_valid_in & armed & (~full | pop);

    // Zero while in reset or empty so the head never shows stale storage.
    assign phv_out = (areset || !phv_valid_out) ? '0 : mem[rd_ptr];

    always_ff @(posedge axis_clk) begin
        if (push) mem[wr_ptr] <= phv_in;
    end

    // armed masks the strobe on the first edge after reset release.
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            phv_count <= '0;
            armed     <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   phv_count <= phv_count + CW'(1);
                2'b01:   phv_count <= phv_count - CW'(1);
                default: phv_count <= phv_count;
            endcase
        end
    end

`ifdef PHV_FIFO_DROP_CNT_EN
    logic drop;
    assign drop = phv_valid_in & armed & full & ~pop;

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset)                         phv_drop_cnt <= '0;
        else if (drop && phv_drop_cnt != '1) phv_drop_cnt <= phv_drop_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_phv_fifo.sv
// Randomized bench for phv_fifo against a queue-based model of the FIFO rules.
module tb_phv_fifo;

    localparam int W     = 1124;
    localparam int DEPTH = 8;
    localparam int ATH   = 6;

    logic                   axis_clk = 1'b0;
    logic                   areset   = 1'b1;
    logic [W-1:0]           phv_in   = '0;
    logic                   phv_valid_in = 1'b0;
    logic                   phv_ready_in = 1'b0;
    logic [W-1:0]           phv_out;
    logic                   phv_valid_out;
    logic [$clog2(DEPTH):0] phv_count;
    logic                   phv_afull;
`ifdef PHV_FIFO_DROP_CNT_EN
    logic [31:0]            phv_drop_cnt;
`endif

    phv_fifo #(.PKT_HDR_LEN(W), .DEPTH(DEPTH), .AFULL_TH(ATH)) dut (
        .axis_clk      (axis_clk),
        .areset        (areset),
        .phv_in        (phv_in),
        .phv_valid_in  (phv_valid_in),
        .phv_out       (phv_out),
        .phv_valid_out (phv_valid_out),
        .phv_ready_in  (phv_ready_in),
        .phv_count     (phv_count),
        .phv_afull     (phv_afull)
`ifdef PHV_FIFO_DROP_CNT_EN
        ,
        .phv_drop_cnt  (phv_drop_cnt)
`endif
    );

    always #5 axis_clk = ~axis_clk;

    int           n_chk = 0;
    int           n_err = 0;
    logic [W-1:0] q[$];
    bit           armed_m = 1'b0;
    longint       exp_drop = 0;
    int           n_push = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h (low 128 bits)", tag, got[127:0], exp[127:0]);
        end
    endtask

    function automatic logic [W-1:0] rnd_phv();
        logic [36*32-1:0] t;
        for (int i = 0; i < 36; i++) t[i*32 +: 32] = $urandom;
        return t[W-1:0];
    endfunction

    task automatic check_state();
        chk("count", W'(phv_count), W'(q.size()));
        chk("valid", W'(phv_valid_out), W'(q.size() > 0));
        chk("afull", W'(phv_afull), W'(q.size() >= ATH));
        if (q.size() > 0) chk("head", phv_out, q[0]);
`ifdef PHV_FIFO_DROP_CNT_EN
        chk("drops", W'(phv_drop_cnt), W'(exp_drop));
`endif
    endtask

    // One clock: hold inputs across the edge, advance the model, then compare.
    task automatic cycle(input bit vin, input logic [W-1:0] d, input bit rdy);
        bit pop_m, push_m;
        phv_valid_in = vin;
        phv_in       = d;
        phv_ready_in = rdy;
        @(posedge axis_clk);
        pop_m  = (q.size() > 0) && rdy;
        push_m = vin && armed_m && ((q.size() < DEPTH) || pop_m);
        if (vin && armed_m && q.size() == DEPTH && !pop_m && exp_drop < 64'hFFFF_FFFF) exp_drop++;
        if (pop_m)  void'(q.pop_front());
        if (push_m) begin q.push_back(d); n_push++; end
        armed_m = 1'b1;
        #1;
        check_state();
    endtask

    task automatic do_reset();
        areset = 1'b1;
        #2;
        chk("rst_valid", W'(phv_valid_out), '0);
        chk("rst_count", W'(phv_count), '0);
        chk("rst_afull", W'(phv_afull), '0);
        chk("rst_out", phv_out, '0);
`ifdef PHV_FIFO_DROP_CNT_EN
        chk("rst_drops", W'(phv_drop_cnt), '0);
`endif
        q.delete();
        exp_drop = 0;
        armed_m  = 1'b0;
        @(posedge axis_clk);
        #1;
        areset = 1'b0;
    endtask

    initial begin
        logic [W-1:0] a5;
        #3;
        do_reset();

        // First strobe after reset release must be ignored.
        cycle(1'b1, rnd_phv(), 1'b1);
        chk("ignore_first", W'(phv_count), '0);

        // Single push into empty FIFO, popped next cycle.
        a5 = {(W+7)/8{8'hA5}};
        cycle(1'b1, a5, 1'b1);
        chk("a5_out", phv_out, a5);
        cycle(1'b0, '0, 1'b1);

        // Ten pushes with no consumer: two drops, then ordered drain.
        for (int i = 0; i < 10; i++) cycle(1'b1, rnd_phv(), 1'b0);
        chk("full_count", W'(phv_count), W'(DEPTH));
        chk("exp_drop2", W'(exp_drop), W'(2));
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, rnd_phv(), 1'b0);
        cycle(1'b1, rnd_phv(), 1'b1);
        chk("full_pushpop", W'(phv_count), W'(DEPTH));
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);

        // Random traffic until at least 40 pushes, then drain.
        n_push = 0;
        for (int i = 0; i < 400 && n_push < 40; i++)
            cycle(bit'($urandom_range(0, 1)), rnd_phv(), bit'($urandom_range(0, 1)));
        chk("rand_pushes", W'(n_push >= 40), W'(1));
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1);

        // Mid-operation reset with five entries stored.
        for (int i = 0; i < 5; i++) cycle(1'b1, rnd_phv(), 1'b0);
        chk("pre_rst_count", W'(phv_count), W'(5));
        do_reset();
        cycle(1'b0, '0, 1'b0);
        cycle(1'b1, rnd_phv(), 1'b0);
        chk("post_rst_count", W'(phv_count), W'(1));
        cycle(1'b0, '0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
